msg_controller_rr: RTL and testbench

- Next-generation system controller for the delay-line test harness.
- Polls NUM_CH memory-manager channels round-robin, plus the UART input message FIFO.
- Decodes host messages (run control, params, number replacement, channel enable) and queues responses/reports in an internal output FIFO feeding the UART transmitter.
- Any error halts the system; an explicit clear message recovers it without reset.

---
 rtl/msg_controller_pkg.sv | 25 ++
 rtl/msg_controller_rr_if.sv | 15 +
 rtl/msg_out_fifo.sv | 45 ++++
 rtl/msg_controller_rr.sv | 174 +++++++++++++++++
 tb/tb_msg_controller_rr.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_controller_pkg.sv
// Shared constants for the delay-line harness message controller:
// header codes, default parameter words and FSM state encodings.
package msg_controller_pkg;
  localparam int HDR_W = 8;

  localparam logic [HDR_W-1:0] ACK                   = 8'h01;
  localparam logic [HDR_W-1:0] RECEIVED_NUM          = 8'h02;
  localparam logic [HDR_W-1:0] REPLACE_NUM           = 8'h03;
  localparam logic [HDR_W-1:0] MOD_PARAMS            = 8'h04;
  localparam logic [HDR_W-1:0] MEM_PARAMS            = 8'h05;
  localparam logic [HDR_W-1:0] SYS_STATUS            = 8'h06;
  localparam logic [HDR_W-1:0] CH_ENABLE             = 8'h07;
  localparam logic [HDR_W-1:0] ERR_MEM_OVERRUN       = 8'h81;
  localparam logic [HDR_W-1:0] ERR_FIFO_FULL         = 8'h82;
  localparam logic [HDR_W-1:0] ERR_UPDATE_WHILST_RUN = 8'h83;
  localparam logic [HDR_W-1:0] ERR_INVALID_MSG       = 8'h84;

  localparam logic [31:0] DEFAULT_MOD_PARAMS = 32'h0000_0100;
  localparam logic [31:0] DEFAULT_MEM_PARAMS = 32'h0000_0040;

  localparam logic [1:0] S_POLL_CH = 2'd0;
  localparam logic [1:0] S_POLL_IN = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;
endpackage

// File: rtl/msg_controller_rr_if.sv
// UART-side message handshakes: input FIFO head/pop and output message stream.
interface msg_controller_rr_if #(parameter int MSG_W = 40) ();
  logic             in_valid;
  logic [MSG_W-1:0] in_msg;
  logic             in_full;
  logic             in_ready;
  logic             out_valid;
  logic [MSG_W-1:0] out_msg;
  logic             out_ready;

  modport master (input in_valid, in_msg, in_full, out_ready,
                  output in_ready, out_valid, out_msg);
  modport slave  (output in_valid, in_msg, in_full, out_ready,
                  input in_ready, out_valid, out_msg);
endinterface

// File: rtl/msg_out_fifo.sv
// First-word-fall-through output queue; push is ignored when full.
module msg_out_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (int'(count) < DEPTH);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/msg_controller_rr.sv
// System controller: round-robin channel poll, host message decode, response queue.
// Error responses halt the system until a SYS_STATUS clear message arrives.
module msg_controller_rr
  import msg_controller_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MSG_W     = 40,
  parameter int NUM_W     = 16,
  parameter int PARAM_W   = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      n_reset,
  msg_controller_rr_if.master       bus,
  output logic                      run,
  output logic                      halted,
  input  logic [NUM_CH*NUM_W-1:0]   ch_num,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_overrun,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic [NUM_W-1:0]          replace_num,
  output logic [NUM_CH-1:0]         replace_valid,
  output logic [NUM_CH-1:0]         ch_enable,
  output logic [PARAM_W-1:0]        mod_params,
  output logic [PARAM_W-1:0]        mem_params
);
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAY_W    = MSG_W - HDR_W;
  localparam logic [PAY_W-1:0] ZERO_PAY = '0;

  logic [1:0]                 state, state_nxt;
  logic [CH_IDX_W-1:0]        rr_ptr, rr_nxt, sel;
  logic [MSG_W-1:0]           staged, staged_nxt;
  logic                       run_nxt, halted_nxt, found, can_push, pop_in;
  logic [NUM_CH-1:0]          en_nxt;
  logic [PARAM_W-1:0]         mod_nxt, mem_nxt;
  logic [$clog2(OUT_DEPTH):0] fifo_cnt;
  logic                       fifo_empty;
  logic [NUM_CH-1:0][NUM_W-1:0] ch_num_a;

  logic [HDR_W-1:0]       in_hdr;
  logic [PAY_W-1:0]       in_pay;
  logic [PAY_W-NUM_W-1:0] rep_ch;
  logic                   rep_ok;
  logic [MSG_W-1:0]       ack_msg;

  assign ch_num_a = ch_num;
  assign in_hdr   = bus.in_msg[MSG_W-1 -: HDR_W];
  assign in_pay   = bus.in_msg[PAY_W-1:0];
  assign rep_ch   = in_pay[PAY_W-1:NUM_W];
  assign rep_ok   = int'(rep_ch) < NUM_CH;
  assign ack_msg  = {ACK, in_hdr, in_pay[PAY_W-HDR_W-1:0]};
  assign can_push = int'(fifo_cnt) < OUT_DEPTH;

  // First enabled channel with activity, scanning upward from rr_ptr with wrap.
  always_comb begin
    logic [CH_IDX_W-1:0] c;
    found = 1'b0;
    sel   = '0;
    c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = CH_IDX_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!found && ch_enable[c] && (ch_valid[c] || ch_overrun[c])) begin
        found = 1'b1;
        sel   = c;
      end
    end
  end

  assign pop_in = (state == S_POLL_IN && !bus.in_full && bus.in_valid) ||
                  (state == S_HALT && bus.in_valid);
  assign bus.in_ready  = n_reset && pop_in;
  assign ch_ack        = (n_reset && state == S_POLL_CH && found && !ch_overrun[sel])
                         ? (NUM_CH'(1) << sel) : '0;
  assign replace_valid = (n_reset && state == S_POLL_IN && pop_in &&
                          in_hdr == REPLACE_NUM && rep_ok) ? (NUM_CH'(1) << rep_ch) : '0;
  assign replace_num   = in_pay[NUM_W-1:0];

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    staged_nxt = staged;
    run_nxt    = run;
    halted_nxt = halted;
    en_nxt     = ch_enable;
    mod_nxt    = mod_params;
    mem_nxt    = mem_params;
    case (state)
      S_POLL_CH: begin
        if (!found) state_nxt = S_POLL_IN;
        else begin
          state_nxt = S_EMIT;
          if (ch_overrun[sel]) staged_nxt = {ERR_MEM_OVERRUN, PAY_W'(sel)};
          else begin
            staged_nxt = {RECEIVED_NUM, PAY_W'({sel, ch_num_a[sel]})};
            rr_nxt     = (sel == CH_IDX_W'(NUM_CH-1)) ? '0 : sel + 1'b1;
          end
        end
      end
      S_POLL_IN: begin
        state_nxt = S_EMIT;
        if (bus.in_full) staged_nxt = {ERR_FIFO_FULL, ZERO_PAY};
        else if (!bus.in_valid) state_nxt = S_POLL_CH;
        else begin
          staged_nxt = ack_msg;
          case (in_hdr)
            REPLACE_NUM: if (!rep_ok) staged_nxt = {ERR_INVALID_MSG, ZERO_PAY};
            MOD_PARAMS:
              if (run) staged_nxt = {ERR_UPDATE_WHILST_RUN, ZERO_PAY};
              else     mod_nxt    = in_pay[PARAM_W-1:0];
            MEM_PARAMS:
              if (run) staged_nxt = {ERR_UPDATE_WHILST_RUN, ZERO_PAY};
              else     mem_nxt    = in_pay[PARAM_W-1:0];
            SYS_STATUS:  run_nxt = in_pay[0];
            CH_ENABLE:   en_nxt  = in_pay[NUM_CH-1:0];
            default:     staged_nxt = {ERR_INVALID_MSG, ZERO_PAY};
          endcase
        end
      end
      S_EMIT: begin
        if (can_push) begin
          if (staged[MSG_W-1]) begin
            run_nxt    = 1'b0;
            halted_nxt = 1'b1;
            state_nxt  = S_HALT;
          end else state_nxt = S_POLL_CH;
        end
      end
      default: begin
        // Halted: every input is popped; only a CLEAR status message is answered.
        run_nxt = 1'b0;
        if (bus.in_valid && in_hdr == SYS_STATUS && in_pay[1]) begin
          staged_nxt = ack_msg;
          halted_nxt = 1'b0;
          state_nxt  = S_EMIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= S_POLL_CH;
      rr_ptr     <= '0;
      staged     <= '0;
      run        <= 1'b0;
      halted     <= 1'b0;
      ch_enable  <= '1;
      mod_params <= PARAM_W'(DEFAULT_MOD_PARAMS);
      mem_params <= PARAM_W'(DEFAULT_MEM_PARAMS);
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      staged     <= staged_nxt;
      run        <= run_nxt;
      halted     <= halted_nxt;
      ch_enable  <= en_nxt;
      mod_params <= mod_nxt;
      mem_params <= mem_nxt;
    end
  end

  msg_out_fifo #(.W(MSG_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (state == S_EMIT),
    .din     (staged),
    .pop     (bus.out_valid && bus.out_ready),
    .dout    (bus.out_msg),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );
  assign bus.out_valid = !fifo_empty;
endmodule

// File: tb/tb_msg_controller_rr.sv
// Scenario bench for msg_controller_rr: expected responses are queued when stimulus
// is issued and checked in order as the output stream drains.
module tb_msg_controller_rr;
  import msg_controller_pkg::*;
  localparam int NUM_CH = 4, MSG_W = 40, NUM_W = 16, PARAM_W = 32, OUT_DEPTH = 4;
  localparam int PAY_W = MSG_W - HDR_W;
  localparam logic [MSG_W-1:0] M_ALL = '1;
  localparam logic [MSG_W-1:0] M_HDR = {8'hFF, {PAY_W{1'b0}}};

  logic clk = 1'b0, n_reset = 1'b0;
  always #5 clk = ~clk;

  msg_controller_rr_if #(.MSG_W(MSG_W)) bus ();
  logic run, halted;
  logic [NUM_CH*NUM_W-1:0] ch_num;
  logic [NUM_CH-1:0] ch_valid, ch_overrun, ch_ack, replace_valid, ch_enable;
  logic [NUM_W-1:0] replace_num;
  logic [PARAM_W-1:0] mod_params, mem_params;

  msg_controller_rr #(.NUM_CH(NUM_CH), .MSG_W(MSG_W), .NUM_W(NUM_W),
                      .PARAM_W(PARAM_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .run(run), .halted(halted),
    .ch_num(ch_num), .ch_valid(ch_valid), .ch_overrun(ch_overrun), .ch_ack(ch_ack),
    .replace_num(replace_num), .replace_valid(replace_valid), .ch_enable(ch_enable),
    .mod_params(mod_params), .mem_params(mem_params));

  int n_tests = 0, n_fail = 0;
  logic [MSG_W-1:0] host_q[$], exp_q[$], mask_q[$];
  logic [NUM_CH-1:0] ch_set = '0, ch_clr = '0, ovr_req = '0, hp_ack;
  logic full_req = 1'b0, hp_pop, prev_ov = 1'b0;
  int out_mode = 1, cyc = 0, pop_cyc = 0, rise_cyc = 0, rep_pulses = 0;
  int ack_cnt[NUM_CH];
  logic [NUM_CH-1:0] rep_seen = '0;
  logic [NUM_W-1:0] rep_num_seen = '0;
  logic [MSG_W-1:0] mon_e, mon_m;

  function automatic logic [MSG_W-1:0] mk(input logic [7:0] h, input logic [PAY_W-1:0] p);
    return {h, p};
  endfunction

  function automatic logic [PAY_W-1:0] rx_pay(input int c, input logic [NUM_W-1:0] n);
    return (PAY_W'(c) << NUM_W) | PAY_W'(n);
  endfunction

  function automatic void expect_msg(input logic [MSG_W-1:0] m, input logic [MSG_W-1:0] k);
    exp_q.push_back(m & k);
    mask_q.push_back(k);
  endfunction

  // Host model: input FIFO, channel sources and transmitter, updated just after each edge.
  initial begin
    bus.in_valid = 1'b0; bus.in_msg = '0; bus.in_full = 1'b0; bus.out_ready = 1'b1;
    ch_valid = '0; ch_overrun = '0; ch_num = '0;
    forever begin
      @(negedge clk); hp_pop = bus.in_ready; hp_ack = ch_ack;
      @(posedge clk); #1;
      cyc++;
      if (hp_pop && host_q.size() > 0) void'(host_q.pop_front());
      ch_valid = (ch_valid & ~hp_ack & ~ch_clr) | ch_set;
      ch_set = '0; ch_clr = '0;
      ch_overrun = ovr_req;
      bus.in_full = full_req;
      bus.in_valid = host_q.size() > 0;
      bus.in_msg = (host_q.size() > 0) ? host_q[0] : '0;
      bus.out_ready = (out_mode == 1) ? 1'b1 : (out_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Output scoreboard and strobe observers.
  initial forever begin
    @(negedge clk);
    if (n_reset) begin
      if (bus.in_ready) pop_cyc = cyc;
      if (bus.out_valid && !prev_ov) rise_cyc = cyc;
      for (int c = 0; c < NUM_CH; c++) if (ch_ack[c]) ack_cnt[c]++;
      if (replace_valid != '0) begin
        rep_pulses++; rep_seen = replace_valid; rep_num_seen = replace_num;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %h, required no message", bus.out_msg);
        end else begin
          mon_e = exp_q.pop_front(); mon_m = mask_q.pop_front();
          if ((bus.out_msg & mon_m) !== mon_e) begin
            n_fail++;
            $display("FAIL out_msg: got %h, required %h (mask %h)", bus.out_msg, mon_e, mon_m);
          end
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic wait_drain(output bit ok);
    int k = 0;
    while ((exp_q.size() > 0 || host_q.size() > 0) && k < 500) begin
      @(posedge clk); k++;
    end
    ok = (exp_q.size() == 0);
    repeat (6) @(posedge clk);
  endtask

  task automatic clear_acks();
    for (int c = 0; c < NUM_CH; c++) ack_cnt[c] = 0;
  endtask

  task automatic send(input logic [MSG_W-1:0] m);
    @(negedge clk); host_q.push_back(m);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (run !== 1'b0 || halted !== 1'b0) begin n_fail++;
      $display("FAIL reset_run_halted: got %b%b, required 00", run, halted); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b0 || ch_ack !== '0 || replace_valid !== '0) begin n_fail++;
      $display("FAIL reset_strobes: got %b %b %b, required all 0", bus.in_ready, ch_ack, replace_valid); end
    n_tests++; if (ch_enable !== 4'b1111) begin n_fail++;
      $display("FAIL reset_ch_enable: got %b, required 1111", ch_enable); end
    n_tests++; if (mod_params !== DEFAULT_MOD_PARAMS || mem_params !== DEFAULT_MEM_PARAMS) begin n_fail++;
      $display("FAIL reset_params: got %h %h, required %h %h", mod_params, mem_params,
               DEFAULT_MOD_PARAMS, DEFAULT_MEM_PARAMS); end
    n_reset = 1'b1;
  endtask

  task automatic test_rr_order();
    bit ok;
    out_mode = 2;
    for (int b = 0; b < 2; b++) begin
      clear_acks();
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        ch_num[c*NUM_W +: NUM_W] = NUM_W'(16'h1A00 + 16'h0100 * b + c);
        expect_msg(mk(RECEIVED_NUM, rx_pay(c, NUM_W'(16'h1A00 + 16'h0100 * b + c))), M_ALL);
      end
      ch_set = '1;
      wait_drain(ok);
      n_tests++; if (!ok) begin n_fail++;
        $display("FAIL rr_drain: %0d messages still owed, required 0", exp_q.size()); end
      for (int c = 0; c < NUM_CH; c++) begin
        n_tests++; if (ack_cnt[c] != 1) begin n_fail++;
          $display("FAIL rr_ack_count ch%0d burst%0d: got %0d, required 1", c, b, ack_cnt[c]); end
      end
    end
    out_mode = 1;
  endtask

  task automatic test_run_params();
    bit ok;
    expect_msg(mk(ACK, {MOD_PARAMS, 24'hFEF00D}), M_ALL);
    send(mk(MOD_PARAMS, 32'hCAFE_F00D));
    wait_drain(ok);
    n_tests++; if (!ok || mod_params !== 32'hCAFE_F00D) begin n_fail++;
      $display("FAIL params_stopped: got %h (drained %0b), required cafef00d", mod_params, ok); end
    expect_msg(mk(ACK, {SYS_STATUS, 24'h000001}), M_ALL);
    send(mk(SYS_STATUS, 32'h1));
    wait_drain(ok);
    n_tests++; if (!ok || run !== 1'b1) begin n_fail++;
      $display("FAIL run_set: got run=%b (drained %0b), required 1", run, ok); end
    expect_msg(mk(ERR_UPDATE_WHILST_RUN, '0), M_HDR);
    send(mk(MOD_PARAMS, 32'h1234_5678));
    wait_drain(ok);
    n_tests++; if (!ok || mod_params !== 32'hCAFE_F00D) begin n_fail++;
      $display("FAIL params_while_run: got %h (drained %0b), required cafef00d", mod_params, ok); end
    n_tests++; if (run !== 1'b0 || halted !== 1'b1) begin n_fail++;
      $display("FAIL error_halts: got run=%b halted=%b, required 0 1", run, halted); end
  endtask

  task automatic test_halt_clear();
    bit ok;
    send(mk(MEM_PARAMS, 32'h55));
    wait_drain(ok);
    n_tests++; if (host_q.size() != 0 || mem_params !== DEFAULT_MEM_PARAMS || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_discard: got q=%0d mem=%h halted=%b, required 0 %h 1",
                         host_q.size(), mem_params, halted, DEFAULT_MEM_PARAMS); end
    expect_msg(mk(ACK, {SYS_STATUS, 24'h000002}), M_ALL);
    send(mk(SYS_STATUS, 32'h2));
    wait_drain(ok);
    n_tests++; if (!ok || halted !== 1'b0 || run !== 1'b0) begin n_fail++;
      $display("FAIL halt_clear: got halted=%b run=%b (drained %0b), required 0 0", halted, run, ok); end
    clear_acks();
    @(negedge clk);
    ch_num[1*NUM_W +: NUM_W] = 16'h1111;
    expect_msg(mk(RECEIVED_NUM, rx_pay(1, 16'h1111)), M_ALL);
    ch_set = 4'b0010;
    wait_drain(ok);
    n_tests++; if (!ok || ack_cnt[1] != 1) begin n_fail++;
      $display("FAIL poll_resumes: got acks=%0d (drained %0b), required 1", ack_cnt[1], ok); end
  endtask

  task automatic test_ch_enable();
    bit ok;
    expect_msg(mk(ACK, {CH_ENABLE, 24'h000005}), M_ALL);
    send(mk(CH_ENABLE, 32'h5));
    wait_drain(ok);
    n_tests++; if (!ok || ch_enable !== 4'b0101) begin n_fail++;
      $display("FAIL ch_enable_set: got %b (drained %0b), required 0101", ch_enable, ok); end
    clear_acks();
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) ch_num[c*NUM_W +: NUM_W] = NUM_W'(16'h2C00 + c);
    // rr pointer sits at 2 after the previous ch1 report
    expect_msg(mk(RECEIVED_NUM, rx_pay(2, 16'h2C02)), M_ALL);
    expect_msg(mk(RECEIVED_NUM, rx_pay(0, 16'h2C00)), M_ALL);
    ch_set = '1;
    wait_drain(ok);
    repeat (10) @(posedge clk);
    n_tests++; if (!ok || ack_cnt[0] != 1 || ack_cnt[1] != 0 || ack_cnt[2] != 1 || ack_cnt[3] != 0) begin
      n_fail++; $display("FAIL ch_enable_mask: got acks %0d %0d %0d %0d, required 1 0 1 0",
                         ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]); end
    @(negedge clk); ch_clr = '1;
    repeat (3) @(posedge clk);
    expect_msg(mk(ACK, {CH_ENABLE, 24'h00000F}), M_ALL);
    send(mk(CH_ENABLE, 32'hF));
    wait_drain(ok);
  endtask

  task automatic test_backpressure();
    bit ok;
    out_mode = 0;
    clear_acks();
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) ch_num[c*NUM_W +: NUM_W] = NUM_W'(16'h3B00 + c);
    for (int i = 0; i < NUM_CH; i++)
      expect_msg(mk(RECEIVED_NUM, rx_pay((1 + i) % NUM_CH, NUM_W'(16'h3B00 + (1 + i) % NUM_CH))), M_ALL);
    expect_msg(mk(ACK, {CH_ENABLE, 24'h00000F}), M_ALL);
    expect_msg(mk(ACK, {CH_ENABLE, 24'h00000F}), M_ALL);
    ch_set = '1;
    repeat (2) @(posedge clk);
    send(mk(CH_ENABLE, 32'hF));
    send(mk(CH_ENABLE, 32'hF));
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_tests++; if (host_q.size() != 1 || exp_q.size() != 6 || bus.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL stall_hold: got inq=%0d owed=%0d out_valid=%b, required 1 6 1",
               host_q.size(), exp_q.size(), bus.out_valid); end
    out_mode = 1;
    wait_drain(ok);
    n_tests++; if (!ok || ack_cnt[0] != 1 || ack_cnt[1] != 1 || ack_cnt[2] != 1 || ack_cnt[3] != 1) begin
      n_fail++; $display("FAIL stall_no_loss: got owed=%0d acks %0d %0d %0d %0d, required 0 and 1 each",
                         exp_q.size(), ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]); end
  endtask

  task automatic test_replace();
    bit ok;
    rep_pulses = 0;
    expect_msg(mk(ACK, {REPLACE_NUM, 24'h02BEEF}), M_ALL);
    send(mk(REPLACE_NUM, 32'h0002_BEEF));
    wait_drain(ok);
    n_tests++; if (!ok || rep_pulses != 1 || rep_seen !== 4'b0100 || rep_num_seen !== 16'hBEEF) begin
      n_fail++; $display("FAIL replace_strobe: got pulses=%0d mask=%b num=%h, required 1 0100 beef",
                         rep_pulses, rep_seen, rep_num_seen); end
    n_tests++; if (rise_cyc - pop_cyc != 2) begin n_fail++;
      $display("FAIL replace_latency: got %0d cycles, required 2", rise_cyc - pop_cyc); end
  endtask

  task automatic test_errors();
    bit ok;
    expect_msg(mk(ERR_INVALID_MSG, '0), M_HDR);
    send(mk(REPLACE_NUM, 32'h0004_1234));
    wait_drain(ok);
    n_tests++; if (!ok || rep_pulses != 1 || halted !== 1'b1) begin n_fail++;
      $display("FAIL replace_bad_ch: got pulses=%0d halted=%b, required 1 1", rep_pulses, halted); end
    send(mk(8'h09, 32'h0));
    expect_msg(mk(ACK, {SYS_STATUS, 24'h000002}), M_ALL);
    send(mk(SYS_STATUS, 32'h2));
    wait_drain(ok);
    // input FIFO full reports an error and pops nothing
    @(negedge clk); full_req = 1'b1;
    expect_msg(mk(ERR_FIFO_FULL, '0), M_HDR);
    wait_drain(ok);
    n_tests++; if (!ok || halted !== 1'b1) begin n_fail++;
      $display("FAIL fifo_full_err: got halted=%b (drained %0b), required 1", halted, ok); end
    @(negedge clk); full_req = 1'b0;
    expect_msg(mk(ACK, {SYS_STATUS, 24'h000002}), M_ALL);
    send(mk(SYS_STATUS, 32'h2));
    wait_drain(ok);
    clear_acks();
    @(negedge clk);
    expect_msg(mk(ERR_MEM_OVERRUN, PAY_W'(3)), M_ALL);
    ovr_req = 4'b1000; ch_set = 4'b1000;
    wait_drain(ok);
    n_tests++; if (!ok || ack_cnt[3] != 0 || halted !== 1'b1) begin n_fail++;
      $display("FAIL overrun: got acks=%0d halted=%b (drained %0b), required 0 1", ack_cnt[3], halted, ok); end
    @(negedge clk); ovr_req = '0; ch_clr = '1;
    repeat (3) @(posedge clk);
    expect_msg(mk(ACK, {SYS_STATUS, 24'h000002}), M_ALL);
    send(mk(SYS_STATUS, 32'h2));
    wait_drain(ok);
  endtask

  task automatic test_reset_mid();
    out_mode = 0;
    @(negedge clk);
    ch_set = '1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b0;
    exp_q.delete(); mask_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0 || mod_params !== DEFAULT_MOD_PARAMS || run !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got out_valid=%b mod=%h run=%b, required 0 %h 0",
                         bus.out_valid, mod_params, run, DEFAULT_MOD_PARAMS); end
    n_reset = 1'b1;
    out_mode = 1;
  endtask

  initial begin
    clear_acks();
    test_reset();
    test_rr_order();
    test_run_params();
    test_halt_clear();
    test_ch_enable();
    test_backpressure();
    test_replace();
    test_errors();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
